// File: rtl/demux_pkg.sv
// ============================================================================
// Module   : demux_pkg
// Purpose  : Shared constants and FSM state type for the 1:4 stream demux.
// Revision : 1.0
// ============================================================================
`default_nettype none

package demux_pkg;

   localparam int N_OUT = 4;
   localparam int SEL_W = 2;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

endpackage : demux_pkg

`default_nettype wire

// File: rtl/demux_slot.sv
// ============================================================================
// Module   : demux_slot
// Purpose  : One-entry registered valid/ready slot carrying a beat and its last flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module demux_slot #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_last,
   input  logic              i_ready,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic              o_last
);

   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic              r_last;

   // A load wins over a drain so that a simultaneous drain+load keeps valid high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_last  <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
         r_last  <= i_last;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_last  = r_last;

endmodule : demux_slot

`default_nettype wire

// File: rtl/demux_1x4_stream.sv
// ============================================================================
// Module   : demux_1x4_stream
// Purpose  : Routes whole packets from one valid/ready stream to one of four
//            registered output channels, locking the select for the packet.
// Revision : 1.0
// ============================================================================
`default_nettype none

module demux_1x4_stream
   import demux_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_W-1:0]       in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_last,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [N_OUT*DATA_W-1:0] out_data,
   output logic [N_OUT-1:0]        out_last,
   output logic [N_OUT-1:0]        out_valid,
   input  logic [N_OUT-1:0]        out_ready
);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [SEL_W-1:0]   r_lock_sel;
   logic [SEL_W-1:0]   w_lock_sel_nxt;
   logic [SEL_W-1:0]   w_target;
   logic               w_in_ready;
   logic               w_accept;
   logic [N_OUT-1:0]   w_load;

   // in_sel only steers the first beat; later beats follow the locked channel.
   assign w_target   = (r_state == LOCKED) ? r_lock_sel : in_sel;
   assign w_in_ready = ~out_valid[w_target] | out_ready[w_target];
   assign w_accept   = in_valid & w_in_ready;
   assign in_ready   = w_in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_lock_sel <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_lock_sel <= w_lock_sel_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_lock_sel_nxt = r_lock_sel;
      case (r_state)
         IDLE: begin
            if (w_accept && !in_last) begin
               w_state_nxt    = LOCKED;
               w_lock_sel_nxt = in_sel;
            end
         end
         LOCKED: begin
            if (w_accept && in_last) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   for (genvar k = 0; k < N_OUT; k++) begin : g_slot
      assign w_load[k] = w_accept && (w_target == SEL_W'(k));

      demux_slot #(
         .DATA_W (DATA_W)
      ) u_slot (
         .clk     (clk),
         .rst     (rst),
         .i_load  (w_load[k]),
         .i_data  (in_data),
         .i_last  (in_last),
         .i_ready (out_ready[k]),
         .o_valid (out_valid[k]),
         .o_data  (out_data[k*DATA_W +: DATA_W]),
         .o_last  (out_last[k])
      );
   end

endmodule : demux_1x4_stream

`default_nettype wire

// File: tb/tb_demux_1x4_stream.sv
// ============================================================================
// Module   : tb_demux_1x4_stream
// Purpose  : Directed bench with a per-channel scoreboard for demux_1x4_stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_demux_1x4_stream;

   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic [1:0]        in_sel = '0;
   logic              in_last = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [4*DATA_W-1:0] out_data;
   logic [3:0]        out_last;
   logic [3:0]        out_valid;
   logic [3:0]        out_ready = 4'b1111;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference routing model and per-channel expected beats {last, data}.
   logic [8:0] sb_q [0:3][$];
   logic       m_locked = 1'b0;
   logic [1:0] m_lock   = '0;

   demux_1x4_stream #(.DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_last   (in_last),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic send_beat(input logic [7:0] d, input logic [1:0] s, input logic l,
                            output int waits);
      in_data  = d;
      in_sel   = s;
      in_last  = l;
      in_valid = 1'b1;
      waits    = 0;
      @(negedge clk);
      while (!in_ready && waits < 20) begin
         waits++;
         @(negedge clk);
      end
      if (!in_ready) check("send_timeout", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic monitor_step();
      logic [1:0] tgt;
      logic [8:0] exp_beat;
      if (rst) begin
         for (int k = 0; k < 4; k++) sb_q[k].delete();
         m_locked = 1'b0;
         m_lock   = '0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (out_valid[k] === 1'b1 && out_ready[k] === 1'b1) begin
               if (sb_q[k].size() == 0) begin
                  check($sformatf("unexpected_beat_ch%0d", k), {28'b0, out_valid}, 32'd0);
               end else begin
                  exp_beat = sb_q[k].pop_front();
                  check($sformatf("sb_beat_ch%0d", k),
                        {23'b0, out_last[k], out_data[k*DATA_W +: DATA_W]},
                        {23'b0, exp_beat});
               end
            end
         end
         if (in_valid && in_ready === 1'b1) begin
            tgt = m_locked ? m_lock : in_sel;
            sb_q[tgt].push_back({in_last, in_data});
            if (!m_locked && !in_last) begin
               m_locked = 1'b1;
               m_lock   = in_sel;
            end else if (m_locked && in_last) begin
               m_locked = 1'b0;
            end
         end
      end
   endtask

   initial begin
      int w;
      fork
         forever begin
            @(negedge clk);
            monitor_step();
         end
      join_none

      // Reset pulse in the middle of a cycle
      #2 rst = 1'b1;
      #1;
      check("reset_out_valid", {28'b0, out_valid}, 32'd0);
      check("reset_out_data", out_data, 32'd0);
      check("reset_out_last", {28'b0, out_last}, 32'd0);
      #9 rst = 1'b0;
      @(posedge clk);
      #1;
      check("idle_in_ready", {31'b0, in_ready}, 32'd1);

      // Single-beat packet to channel 2
      send_beat(8'hA5, 2'd2, 1'b1, w);
      idle_cycle();
      in_valid = 1'b0;
      check("single_valid", {28'b0, out_valid}, 32'd0);
      send_beat(8'hA5, 2'd2, 1'b1, w);
      check("single_out_valid", {28'b0, out_valid}, 32'h4);
      check("single_ch2_data", {24'b0, out_data[23:16]}, 32'hA5);
      check("single_ch2_last", {31'b0, out_last[2]}, 32'd1);

      // Packet lock: in_sel changes mid-packet and must be ignored
      send_beat(8'h11, 2'd1, 1'b0, w);
      check("lock_b1_valid", {28'b0, out_valid}, 32'h2);
      send_beat(8'h22, 2'd3, 1'b0, w);
      check("lock_b2_valid", {28'b0, out_valid}, 32'h2);
      send_beat(8'h33, 2'd3, 1'b1, w);
      check("lock_b3_valid", {28'b0, out_valid}, 32'h2);
      check("lock_b3_data", {24'b0, out_data[15:8]}, 32'h33);
      check("lock_b3_last", {31'b0, out_last[1]}, 32'd1);
      idle_cycle();

      // Backpressure on channel 0, then full-rate release
      out_ready = 4'b1110;
      send_beat(8'h40, 2'd0, 1'b0, w);
      in_data = 8'h41;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_in_ready", {31'b0, in_ready}, 32'd0);
         check("bp_hold_data", {24'b0, out_data[7:0]}, 32'h40);
      end
      @(posedge clk);
      #1;
      out_ready = 4'b1111;
      for (int i = 1; i < 4; i++) begin
         send_beat(8'h40 + 8'(i), 2'd0, (i == 3), w);
         check("tp_no_wait", w, 32'd0);
         check("tp_valid0", {31'b0, out_valid[0]}, 32'd1);
         check("tp_data0", {24'b0, out_data[7:0]}, 32'h40 + i);
      end
      idle_cycle();

      // Channel isolation: channel 0 stalled while channel 3 flows
      out_ready = 4'b1110;
      send_beat(8'h50, 2'd0, 1'b1, w);
      idle_cycle();
      send_beat(8'h7E, 2'd3, 1'b1, w);
      check("iso_no_wait", w, 32'd0);
      check("iso_out_valid", {28'b0, out_valid}, 32'h9);
      check("iso_ch3_data", {24'b0, out_data[31:24]}, 32'h7E);
      check("iso_ch0_data", {24'b0, out_data[7:0]}, 32'h50);
      idle_cycle();
      out_ready = 4'b1111;
      idle_cycle();

      // Reset mid-packet truncates and clears the lock
      send_beat(8'h61, 2'd1, 1'b0, w);
      send_beat(8'h62, 2'd1, 1'b0, w);
      out_ready = 4'b1101;
      in_valid  = 1'b0;
      check("mid_pre_valid", {28'b0, out_valid}, 32'h2);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_valid", {28'b0, out_valid}, 32'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      out_ready = 4'b1111;
      @(posedge clk);
      #1;
      send_beat(8'h70, 2'd0, 1'b1, w);
      check("post_rst_valid", {28'b0, out_valid}, 32'h1);
      check("post_rst_data", {24'b0, out_data[7:0]}, 32'h70);

      // Drain and confirm every expected beat was delivered
      idle_cycle();
      repeat (4) idle_cycle();
      for (int k = 0; k < 4; k++) begin
         check($sformatf("sb_empty_ch%0d", k), sb_q[k].size(), 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_demux_1x4_stream

`default_nettype wire
